// File: rtl/input_reg_readout.sv
// Consumer end of the trigger hit latch. It synchronises the latched hits and merges coincident
// bits into one event, hands the event off over valid/ready, then clears and verifies those channels.
module input_reg_readout #(
   parameter int WIDTH      = 48,
   parameter int WIN        = 4,
   parameter int CLR_LEN    = 2,
   parameter int SETTLE_MAX = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] hit_in,
   output logic [WIDTH-1:0] clr_out,
   output logic [WIDTH-1:0] evt_data,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [15:0]      evt_count,
   output logic             stuck
);

   // One shared down/up counter serves the window, clear-hold and settle phases.
   localparam int MAXC = (WIN > CLR_LEN) ? ((WIN > SETTLE_MAX) ? WIN : SETTLE_MAX)
                                         : ((CLR_LEN > SETTLE_MAX) ? CLR_LEN : SETTLE_MAX);
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [2:0] {
      IDLE,
      WINDOW,
      PRESENT,
      CLEAR,
      SETTLE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] hit_s;
   logic [WIDTH-1:0] snap_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] clr_out_q;
   logic [WIDTH-1:0] evt_data_q;
   logic             evt_valid_q;
   logic [15:0]      evt_count_q;
   logic [15:0]      evt_count_d;
   logic             stuck_q;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_sync
         always_ff @(posedge clk) begin
            if (rst) begin
               sync1_q[gi] <= 1'b0;
               hit_s[gi]   <= 1'b0;
            end else begin
               sync1_q[gi] <= hit_in[gi];
               hit_s[gi]   <= sync1_q[gi];
            end
         end
      end
   endgenerate

   assign evt_count_d = (evt_count_q == 16'hFFFF) ? evt_count_q : evt_count_q + 16'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         snap_q      <= '0;
         cnt_q       <= '0;
         clr_out_q   <= '0;
         evt_data_q  <= '0;
         evt_valid_q <= 1'b0;
         evt_count_q <= '0;
         stuck_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               clr_out_q   <= '0;
               evt_valid_q <= 1'b0;
               if (|hit_s) begin
                  snap_q  <= hit_s;
                  cnt_q   <= CW'(WIN - 1);
                  state_q <= WINDOW;
               end
            end
            WINDOW: begin
               snap_q <= snap_q | hit_s;
               if (cnt_q == '0) state_q <= PRESENT;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            PRESENT: begin
               // First PRESENT cycle only raises valid, so the snapshot is frozen before it is shown.
               if (!evt_valid_q) begin
                  evt_valid_q <= 1'b1;
                  evt_data_q  <= snap_q;
               end else if (evt_ready) begin
                  evt_valid_q <= 1'b0;
                  evt_count_q <= evt_count_d;
                  clr_out_q   <= snap_q;
                  cnt_q       <= CW'(CLR_LEN - 1);
                  state_q     <= CLEAR;
               end
            end
            CLEAR: begin
               if (cnt_q == '0) begin
                  clr_out_q <= '0;
                  cnt_q     <= '0;
                  state_q   <= SETTLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            SETTLE: begin
               // Two blank cycles cover the synchroniser before cleared bits are trusted to read low.
               if (cnt_q >= CW'(2) && (hit_s & snap_q) == '0) begin
                  snap_q  <= '0;
                  state_q <= IDLE;
               end else if (cnt_q == CW'(SETTLE_MAX - 1)) begin
                  stuck_q <= 1'b1;
                  snap_q  <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign clr_out   = clr_out_q;
   assign evt_data  = evt_data_q;
   assign evt_valid = evt_valid_q;
   assign evt_count = evt_count_q;
   assign stuck     = stuck_q;

endmodule

// File: doc/input_reg_readout.md
Name: input_reg_readout

Overview:
- Drains the per-channel hit latch register that catches trigger-input rising edges asynchronously.
- Synchronises the latched hit vector and groups coincident bits inside a fixed window into one event.
- Hands each event downstream over a valid/ready handshake.
- Then drives per-channel clear pulses back to the latch. It is the consumer/clearing end of the latch's set/clear interface.

Parameters:
- WIDTH, 48: number of channels; width of hit and clear vectors.
- WIN, 4: coincidence window length in clk cycles after the first hit; legal range is 1 or more.
- CLR_LEN, 2: number of cycles the clear vector is held high; legal range is 1 or more.
- SETTLE_MAX, 8: maximum cycles to wait for cleared bits to read back low; legal range is 3 or more.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- hit_in  in  WIDTH  latched hit vector from the input latch; asynchronous to clk.
- clr_out  out  WIDTH  per-channel clear to the latch; a high level clears that channel.
- evt_data  out  WIDTH  captured coincidence pattern.
- evt_valid  out  1  evt_data is valid.
- evt_ready  in  1  downstream accepts the event.
- evt_count  out  16  accepted-event counter; saturates at 16'hFFFF.
- stuck  out  1  sticky error: a cleared channel failed to read back low.

Behaviour:
- Synchroniser:
  - hit_s = hit_in through two flops per bit. This adds 2 cycles of latency.
  - Only hit_s is used in the logic.
- Reset (rst high at a clk edge):
  - State goes to IDLE.
  - Synchroniser flops, snapshot, counters, clr_out, evt_data, evt_valid, evt_count and stuck all go to 0.
  - Reset takes effect in any state. If asserted mid-CLEAR, clr_out is 0 on the next edge.
  - Channels still latched upstream are re-captured as a new event after reset.
- IDLE:
  - clr_out = 0 and evt_valid = 0.
  - If hit_s is nonzero: snap <= hit_s, window counter <= WIN-1, go to WINDOW.
- WINDOW:
  - snap <= snap | hit_s every cycle.
  - When the window counter is 0, go to PRESENT. Otherwise decrement.
  - Result: WINDOW lasts exactly WIN cycles.
  - Latency: evt_valid is first high 3+WIN edges after the edge where hit_in is first sampled high.
- PRESENT:
  - evt_valid = 1 and evt_data = snap, held stable until accepted.
  - Bits arriving now are not merged.
  - Handshake: transfer occurs on an edge with evt_valid & evt_ready.
    - evt_valid is 0 on the next cycle.
    - evt_count increments (saturating).
    - State goes to CLEAR.
  - If evt_ready is high on the first PRESENT cycle, evt_valid is high for exactly one cycle.
- CLEAR:
  - clr_out = snap for exactly CLR_LEN cycles, then 0, then go to SETTLE.
  - Channels not in snap are never cleared. They stay latched and form the next event from IDLE, so no hit is lost.
- SETTLE:
  - clr_out = 0.
  - The first 2 cycles are blanked to cover synchroniser delay.
  - From the 3rd cycle on: if (hit_s & snap) == 0, clear snap and go to IDLE.
  - If SETTLE_MAX cycles elapse without that condition: set stuck = 1, clear snap, go to IDLE.
  - stuck is cleared only by rst.
  - A still-high channel will re-trigger an event from IDLE. This is expected and is flagged by stuck.
- evt_data holds its last value outside PRESENT. Checkers sample it only while evt_valid is high.
- No combinational path from evt_ready or hit_in to any output.

Test Plan (WIDTH=48, WIN=4, CLR_LEN=2, SETTLE_MAX=8; latch model clears a bit on clr_out and sets it on stimulus):
1. Single hit on bit 5 at cycle 0, evt_ready=1 → evt_valid high at cycle 7 for 1 cycle, evt_data=48'h20, clr_out=48'h20 for cycles 8-9, back to IDLE, evt_count=1.
2. Coincidence: bits 0 and 47 set 2 cycles apart → one event, evt_data=48'h8000_0000_0001, evt_count=1.
3. Late bit: bit 3 set at cycle 0, bit 9 set at cycle 10 (after window) → two events (48'h8, then 48'h200); bit 9 is never cleared by the first clr_out; evt_count=2.
4. Backpressure: evt_ready=0 for 10 cycles after evt_valid rises → evt_valid and evt_data stable throughout; clr_out stays 0 until the cycle after evt_ready=1.
5. Stuck channel: bit 12 ignores clear → stuck=1 exactly SETTLE_MAX cycles after entering SETTLE; a new event with 48'h1000 follows; stuck remains 1 until rst.
6. Reset mid-CLEAR (rst at first clr_out cycle) → all outputs 0 on the next edge, evt_count=0; the still-latched bit yields a fresh event after rst deasserts.
